// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART transmit and receive blocks: the receiver
//   state encoding and the default frame-format constants.  Both ends of the
//   link must use the same frame format, so the defaults live here.
// -----------------------------------------------------------------------------
package uart_pkg;

    // Default frame format: 8 data bits, 2 stop bits, 50 MHz / 115200 baud.
    localparam int UART_DATA_WIDTH   = 8;
    localparam int UART_STOP_BITS    = 2;
    localparam int UART_CLKS_PER_BIT = 434;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

endpackage : uart_pkg

// File: rtl/uart_sync.sv
// -----------------------------------------------------------------------------
// uart_sync
//   Two-flop synchronizer that brings an asynchronous single-bit input into
//   the clk domain.  Both flops are forced to RST_VAL by reset so that the
//   synchronized output starts at a known, inactive level.
//
// Ports
//   clk  in  1  sampling clock
//   rst  in  1  asynchronous, active-high reset
//   i_d  in  1  asynchronous input
//   o_q  out 1  synchronized output (two clk cycles of latency)
// -----------------------------------------------------------------------------
module uart_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : uart_sync

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   Asynchronous serial receiver.  Synchronizes the RXin line, detects a start
//   bit, samples dataWidth data bits (LSB first) at mid-bit and checks
//   stopBits stop bits.  Each completed frame updates dataOut and produces a
//   single-cycle valid pulse (good frame) or frameErr pulse (a stop bit was 0).
//
// Ports
//   clk       in   1          single clock, rising edge
//   rst       in   1          asynchronous, active-high reset
//   RXin      in   1          serial line, idle high, asynchronous to clk
//   dataOut   out  dataWidth  last received word, held until the next frame
//   valid     out  1          1-cycle pulse: good frame, dataOut updated
//   frameErr  out  1          1-cycle pulse: bad stop bit, dataOut updated
//   busy      out  1          high while a frame is being received
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int dataWidth  = UART_DATA_WIDTH,
    parameter int stopBits   = UART_STOP_BITS,
    parameter int clksPerBit = UART_CLKS_PER_BIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RXin,
    output logic [dataWidth-1:0] dataOut,
    output logic                 valid,
    output logic                 frameErr,
    output logic                 busy
);

    localparam int CNT_W = $clog2(clksPerBit);
    localparam int IDX_W = $clog2(dataWidth + 1);

    localparam logic [CNT_W-1:0] HALF_BIT_LAST = CNT_W'(clksPerBit / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST      = CNT_W'(clksPerBit - 1);
    localparam logic [IDX_W-1:0] DATA_LAST     = IDX_W'(dataWidth - 1);
    localparam logic [IDX_W-1:0] STOP_LAST     = IDX_W'(stopBits - 1);

    logic                 w_rx_s;
    rx_state_t            r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [dataWidth-1:0] r_shift;
    logic                 r_err;
    logic [dataWidth-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_busy;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    uart_sync #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (RXin),
        .o_q (w_rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_err       <= 1'b0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (!w_rx_s) begin
                        r_state <= START;
                        r_busy  <= 1'b1;
                    end
                end

                // Re-check the line half a bit in: a high level means the
                // falling edge was a glitch, not a start bit.
                START: begin
                    if (r_cnt == HALF_BIT_LAST) begin
                        r_cnt <= '0;
                        r_idx <= '0;
                        if (w_rx_s) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                // Shifting in from the top leaves bit 0 (first received) in
                // the LSB after dataWidth samples.
                DATA: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx_s, r_shift[dataWidth-1:1]};
                        if (r_idx == DATA_LAST) begin
                            r_idx   <= '0;
                            r_err   <= 1'b0;
                            r_state <= STOP;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                // Finishing at mid last stop bit leaves half a bit of margin
                // to catch a back-to-back start edge from IDLE.
                STOP: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt <= '0;
                        if (r_idx == STOP_LAST) begin
                            r_idx  <= '0;
                            r_data <= r_shift;
                            r_busy <= 1'b0;
                            if (r_err || !w_rx_s) begin
                                r_frame_err <= 1'b1;
                                r_state     <= BREAK;
                            end else begin
                                r_valid <= 1'b1;
                                r_state <= IDLE;
                            end
                        end else begin
                            r_idx <= r_idx + 1'b1;
                            r_err <= r_err | ~w_rx_s;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                // A line held low after a bad frame must not look like a
                // stream of start bits; wait for it to return high.
                BREAK: begin
                    r_cnt <= '0;
                    if (w_rx_s) begin
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dataOut  = r_data;
    assign valid    = r_valid;
    assign frameErr = r_frame_err;
    assign busy     = r_busy;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//   Directed bench for uart_rx with clksPerBit=16.  A behavioural transmitter
//   task drives RXin; a negedge monitor counts valid/frameErr/busy cycles and
//   captures dataOut on every valid pulse.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int DW  = 8;
    localparam int SB  = 2;
    localparam int CPB = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          RXin = 1'b1;
    logic [DW-1:0] dataOut;
    logic          valid;
    logic          frameErr;
    logic          busy;

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    int n_valid = 0;
    int n_ferr = 0;
    int n_both = 0;
    int n_busy = 0;
    int v_cyc = 0;
    logic [DW-1:0] cap [16];
    logic [DW-1:0] ferr_data = '0;
    int t_start = 0;

    uart_rx #(
        .dataWidth  (DW),
        .stopBits   (SB),
        .clksPerBit (CPB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .RXin     (RXin),
        .dataOut  (dataOut),
        .valid    (valid),
        .frameErr (frameErr),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            cap[n_valid % 16] <= dataOut;
            n_valid <= n_valid + 1;
            v_cyc   <= cyc;
        end
        if (frameErr) begin
            n_ferr    <= n_ferr + 1;
            ferr_data <= dataOut;
        end
        if (valid && frameErr) n_both <= n_both + 1;
        if (busy) n_busy <= n_busy + 1;
    end

    task automatic tx_bit(input logic b);
        @(negedge clk);
        RXin = b;
        repeat (CPB - 1) @(negedge clk);
    endtask

    task automatic tx_frame(input logic [DW-1:0] d, input logic s1, input logic s2);
        @(negedge clk);
        RXin = 1'b0;
        t_start = cyc;
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < DW; i++) tx_bit(d[i]);
        tx_bit(s1);
        tx_bit(s2);
    endtask

    task automatic test_reset;
        int v0, f0;
        rst  = 1'b1;
        RXin = 1'b1;
        #20;
        @(negedge clk);
        total++; if (dataOut !== 8'h00) begin bad++; $display("FAIL reset_dataOut got=%h want=00", dataOut); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
        total++; if (frameErr !== 1'b0) begin bad++; $display("FAIL reset_frameErr got=%b want=0", frameErr); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        rst = 1'b0;
        v0 = n_valid; f0 = n_ferr;
        repeat (3 * CPB) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
        total++; if (n_valid - v0 != 0 || n_ferr - f0 != 0) begin bad++; $display("FAIL idle_pulses valid=%0d ferr=%0d want=0,0", n_valid - v0, n_ferr - f0); end
        total++; if (dataOut !== 8'h00) begin bad++; $display("FAIL idle_dataOut got=%h want=00", dataOut); end
    endtask

    task automatic test_single;
        int v0, f0, lat;
        v0 = n_valid; f0 = n_ferr;
        tx_frame(8'h70, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        total++; if (n_valid - v0 != 1) begin bad++; $display("FAIL single_valid_count got=%0d want=1", n_valid - v0); end
        total++; if (cap[v0 % 16] !== 8'h70) begin bad++; $display("FAIL single_data got=%h want=70", cap[v0 % 16]); end
        total++; if (n_ferr - f0 != 0) begin bad++; $display("FAIL single_ferr got=%0d want=0", n_ferr - f0); end
        lat = v_cyc - t_start;
        total++; if (lat < 168 || lat > 174) begin bad++; $display("FAIL single_latency got=%0d want=168..174", lat); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_after got=%b want=0", busy); end
    endtask

    task automatic test_glitch;
        int v0, f0, b0, bc;
        repeat (CPB) @(negedge clk);
        v0 = n_valid; f0 = n_ferr; b0 = n_busy;
        RXin = 1'b0;
        repeat (3) @(negedge clk);
        RXin = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        bc = n_busy - b0;
        total++; if (bc < 1 || bc > CPB) begin bad++; $display("FAIL glitch_busy_cycles got=%0d want=1..%0d", bc, CPB); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_end got=%b want=0", busy); end
        total++; if (n_valid - v0 != 0 || n_ferr - f0 != 0) begin bad++; $display("FAIL glitch_pulses valid=%0d ferr=%0d want=0,0", n_valid - v0, n_ferr - f0); end
    endtask

    task automatic test_frame_err;
        int v0, f0, b0;
        v0 = n_valid; f0 = n_ferr;
        tx_frame(8'hA5, 1'b1, 1'b0);
        b0 = n_busy;
        repeat (5 * CPB) @(negedge clk);
        total++; if (n_ferr - f0 != 1) begin bad++; $display("FAIL ferr_count got=%0d want=1", n_ferr - f0); end
        total++; if (ferr_data !== 8'hA5) begin bad++; $display("FAIL ferr_data got=%h want=a5", ferr_data); end
        total++; if (dataOut !== 8'hA5) begin bad++; $display("FAIL ferr_dataOut_hold got=%h want=a5", dataOut); end
        total++; if (n_valid - v0 != 0) begin bad++; $display("FAIL ferr_valid got=%0d want=0", n_valid - v0); end
        total++; if (n_busy - b0 != 0) begin bad++; $display("FAIL ferr_busy_while_low got=%0d want=0", n_busy - b0); end
        RXin = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        total++; if (n_ferr - f0 != 1 || n_valid - v0 != 0) begin bad++; $display("FAIL ferr_no_new_frame ferr=%0d valid=%0d want=1,0", n_ferr - f0, n_valid - v0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ferr_busy_end got=%b want=0", busy); end
    endtask

    task automatic test_back_to_back;
        int v0, f0;
        v0 = n_valid; f0 = n_ferr;
        tx_frame(8'h00, 1'b1, 1'b1);
        tx_frame(8'hFF, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        total++; if (n_valid - v0 != 2) begin bad++; $display("FAIL b2b_valid_count got=%0d want=2", n_valid - v0); end
        total++; if (cap[v0 % 16] !== 8'h00) begin bad++; $display("FAIL b2b_first got=%h want=00", cap[v0 % 16]); end
        total++; if (cap[(v0 + 1) % 16] !== 8'hFF) begin bad++; $display("FAIL b2b_second got=%h want=ff", cap[(v0 + 1) % 16]); end
        total++; if (n_ferr - f0 != 0) begin bad++; $display("FAIL b2b_ferr got=%0d want=0", n_ferr - f0); end
    endtask

    task automatic test_reset_mid;
        int v0, f0;
        logic [DW-1:0] d;
        d = 8'h3C;
        repeat (2 * CPB) @(negedge clk);
        v0 = n_valid; f0 = n_ferr;
        @(negedge clk);
        RXin = 1'b0;
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < 4; i++) tx_bit(d[i]);
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before_rst got=%b want=1", busy); end
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy_in_rst got=%b want=0", busy); end
        total++; if (dataOut !== 8'h00) begin bad++; $display("FAIL mid_dataOut_in_rst got=%h want=00", dataOut); end
        RXin = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        total++; if (n_valid - v0 != 0 || n_ferr - f0 != 0) begin bad++; $display("FAIL mid_aborted_output valid=%0d ferr=%0d want=0,0", n_valid - v0, n_ferr - f0); end
        tx_frame(8'h81, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        total++; if (n_valid - v0 != 1) begin bad++; $display("FAIL mid_valid_count got=%0d want=1", n_valid - v0); end
        total++; if (cap[v0 % 16] !== 8'h81) begin bad++; $display("FAIL mid_data got=%h want=81", cap[v0 % 16]); end
        total++; if (n_ferr - f0 != 0) begin bad++; $display("FAIL mid_ferr got=%0d want=0", n_ferr - f0); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_glitch;
        test_frame_err;
        test_back_to_back;
        test_reset_mid;
        total++; if (n_both != 0) begin bad++; $display("FAIL valid_and_ferr_overlap got=%0d want=0", n_both); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_rx
